// File: rtl/mem_pkg.sv
// Shared constants and types for the data memory.
package mem_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Even-parity bit: makes the total number of ones (data + bit) even.
  function automatic logic even_parity(input word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/data_mem_parity.sv
// Parity generate/check for data_mem: one stored even-parity bit per word,
// generated from the write data and checked against the combinational read word.
module data_mem_parity
  import mem_pkg::*;
#(
  parameter int unsigned DataW = DATA_W,
  parameter int unsigned AddrW = ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [DataW-1:0] rdata_i,
  output logic             par_err_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [Depth-1:0] par_q;

  // Parity bits clear asynchronously alongside the data words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= '0;
    end else if (we_i) begin
      par_q[addr_i] <= ^wdata_i;
    end
  end

  // Mismatch between recomputed and stored parity of the addressed word.
  always_comb begin
    par_err_o = (^rdata_i) ^ par_q[addr_i];
  end

endmodule

// File: rtl/data_mem.sv
// Single-port data memory: flop array with async clear, combinational read,
// registered write acknowledge. Optional per-word parity with DATA_MEM_PARITY_EN.
module data_mem
  import mem_pkg::*;
#(
  parameter int unsigned DataW = DATA_W,
  parameter int unsigned AddrW = ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DataW-1:0] dat_in,
  input  logic             wr_en,
  input  logic [AddrW-1:0] addr,
  output logic             done,
`ifdef DATA_MEM_PARITY_EN
  output logic             par_err,
`endif
  output logic [DataW-1:0] dat_out
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic             done_q, done_d;
  logic             we;

  // Unknown write enable resolves to no write.
  always_comb begin
    we = 1'b0;
    if (wr_en) we = 1'b1;
    done_d = we;
  end

  // Storage array; reset clears every word without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[addr] <= dat_in;
    end
  end

  // Write acknowledge follows the accepted write by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= done_d;
  end

  // Read path has no latency.
  always_comb begin
    dat_out = mem_q[addr];
    done    = done_q;
  end

`ifdef DATA_MEM_PARITY_EN
  data_mem_parity #(
    .DataW (DataW),
    .AddrW (AddrW)
  ) u_parity (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (we),
    .addr_i    (addr),
    .wdata_i   (dat_in),
    .rdata_i   (dat_out),
    .par_err_o (par_err)
  );
`endif

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem.
module tb_data_mem;

  logic       clk;
  logic       rst_n;
  logic [7:0] dat_in;
  logic       wr_en;
  logic [7:0] addr;
  logic       done;
  logic [7:0] dat_out;
`ifdef DATA_MEM_PARITY_EN
  logic       par_err;
`endif

  int checks = 0;
  int errors = 0;

  data_mem dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dat_in  (dat_in),
    .wr_en   (wr_en),
    .addr    (addr),
    .done    (done),
`ifdef DATA_MEM_PARITY_EN
    .par_err (par_err),
`endif
    .dat_out (dat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    wr_en  = 1'b0;
    dat_in = 8'h00;
    addr   = 8'h00;
    #1;
    chk("por_done", {7'd0, done}, 8'h00);
    chk("por_dat", dat_out, 8'h00);
    step();
    step();
    rst_n = 1'b1;

    // Dirty a word, then pulse reset mid-sim.
    addr = 8'h10; dat_in = 8'h33; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    chk("pre_rst_dat", dat_out, 8'h33);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    addr = 8'h00; #1 chk("rst_rd00", dat_out, 8'h00);
    addr = 8'h10; #1 chk("rst_rd10", dat_out, 8'h00);
    addr = 8'hFF; #1 chk("rst_rdFF", dat_out, 8'h00);
    chk("rst_done", {7'd0, done}, 8'h00);
    step();

    // Single write then read; old word visible until the edge.
    addr = 8'h10; dat_in = 8'hAA; wr_en = 1'b1;
    #1 chk("wr_old_word", dat_out, 8'h00);
    step();
    wr_en = 1'b0;
    chk("wr_rd10", dat_out, 8'hAA);
    chk("wr_done_hi", {7'd0, done}, 8'h01);
    step();
    chk("wr_done_lo", {7'd0, done}, 8'h00);
    chk("wr_rd10_hold", dat_out, 8'hAA);

    // done across back-to-back writes.
    addr = 8'h20; dat_in = 8'hFF; wr_en = 1'b1;
    step(); chk("b2b_done1", {7'd0, done}, 8'h01);
    step(); chk("b2b_done2", {7'd0, done}, 8'h01);
    step(); chk("b2b_done3", {7'd0, done}, 8'h01);
    wr_en = 1'b0;
    step(); chk("b2b_done_fall", {7'd0, done}, 8'h00);
    chk("b2b_rd20", dat_out, 8'hFF);

    // Address extremes and isolation.
    addr = 8'h00; dat_in = 8'h55; wr_en = 1'b1; step();
    addr = 8'hFF; dat_in = 8'hA5; step();
    wr_en = 1'b0;
    addr = 8'h10; #1 chk("iso_rd10", dat_out, 8'hAA);
    addr = 8'h00; #1 chk("iso_rd00", dat_out, 8'h55);
    addr = 8'hFF; #1 chk("iso_rdFF", dat_out, 8'hA5);
    addr = 8'h20; #1 chk("iso_rd20", dat_out, 8'hFF);
    addr = 8'h7F; #1 chk("iso_rd7F", dat_out, 8'h00);
    step();

    // Reset asserted before the edge of a pending write.
    addr = 8'h31; dat_in = 8'h11; wr_en = 1'b1;
    step();
    chk("mw_done_before", {7'd0, done}, 8'h01);
    addr = 8'h30; dat_in = 8'h77;
    #2 rst_n = 1'b0;
    #1 chk("mw_done_async", {7'd0, done}, 8'h00);
    step();
    rst_n = 1'b1;
    wr_en = 1'b0;
    #1 chk("mw_rd30", dat_out, 8'h00);
    chk("mw_done_after", {7'd0, done}, 8'h00);
    addr = 8'h31; #1 chk("mw_rd31", dat_out, 8'h00);
    addr = 8'h10; #1 chk("mw_rd10", dat_out, 8'h00);
    step();

`ifdef DATA_MEM_PARITY_EN
    addr = 8'h10; dat_in = 8'hAA; wr_en = 1'b1; step();
    addr = 8'h11; dat_in = 8'h01; step();
    wr_en = 1'b0;
    addr = 8'h10; #1 chk("par_clean10", {7'd0, par_err}, 8'h00);
    addr = 8'h11; #1 chk("par_clean11", {7'd0, par_err}, 8'h00);
    dut.mem_q[8'h10] = dut.mem_q[8'h10] ^ 8'h01;
    addr = 8'h10; #1 chk("par_flip10", {7'd0, par_err}, 8'h01);
    addr = 8'h11; #1 chk("par_still11", {7'd0, par_err}, 8'h00);
    addr = 8'h40; #1 chk("par_zero40", {7'd0, par_err}, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
